// File: rtl/mci_mcu_trace_trigger.sv
// MCU trace trigger: registers the raw core trace port and gates packets
// into the trace buffer under a free-run or arm/trigger/post-trigger policy.
module mci_mcu_trace_trigger #(
  parameter int POST_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic                      debug_en,
  input  logic                      cfg_trig_en,
  input  logic                      cfg_arm,
  input  logic                      cfg_disarm,
  input  logic [31:0]               cfg_trig_addr,
  input  logic [31:0]               cfg_trig_mask,
  input  logic                      cfg_trig_on_exc,
  input  logic [POST_CNT_WIDTH-1:0] cfg_post_count,
  input  logic [31:0]               mcu_trace_rv_i_insn_ip,
  input  logic [31:0]               mcu_trace_rv_i_address_ip,
  input  logic [31:0]               mcu_trace_rv_i_tval_ip,
  input  logic                      mcu_trace_rv_i_valid_ip,
  input  logic                      mcu_trace_rv_i_exception_ip,
  input  logic                      mcu_trace_rv_i_interrupt_ip,
  input  logic [4:0]                mcu_trace_rv_i_ecause_ip,
  output logic [31:0]               trace_o_insn,
  output logic [31:0]               trace_o_address,
  output logic [31:0]               trace_o_tval,
  output logic                      trace_o_valid,
  output logic                      trace_o_exception,
  output logic                      trace_o_interrupt,
  output logic [4:0]                trace_o_ecause,
  output logic [1:0]                state,
  output logic                      triggered,
  output logic [POST_CNT_WIDTH-1:0] post_remaining,
  output logic [31:0]               fwd_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic                      trig_q, trig_d;
  logic [POST_CNT_WIDTH-1:0] post_q, post_d;
  logic [31:0]               fwd_cnt_q, fwd_cnt_d;
  logic                      valid_q;
  logic [31:0]               insn_q, addr_q, tval_q;
  logic                      exc_q, intr_q;
  logic [4:0]                ecause_q;
  logic                      fwd;
  logic                      addr_hit;
  logic                      match;

  assign addr_hit =
    (mcu_trace_rv_i_address_ip & cfg_trig_mask) ==
    (cfg_trig_addr & cfg_trig_mask);
  assign match = mcu_trace_rv_i_valid_ip &
    (addr_hit | (cfg_trig_on_exc & mcu_trace_rv_i_exception_ip));

  // Forward decision and FSM next state, judged on the pre-transition state
  always_comb begin
    fwd     = 1'b0;
    state_d = state_q;
    trig_d  = trig_q;
    post_d  = post_q;
    if (!debug_en) begin
      state_d = IDLE;
      trig_d  = 1'b0;
      post_d  = '0;
    end else if (!cfg_trig_en) begin
      fwd     = mcu_trace_rv_i_valid_ip;
      state_d = IDLE;
    end else begin
      fwd = mcu_trace_rv_i_valid_ip &
        ((state_q == ARMED) | (state_q == POST));
      if (cfg_disarm) begin
        state_d = IDLE;
        trig_d  = 1'b0;
        post_d  = '0;
      end else if (cfg_arm) begin
        state_d = ARMED;
        trig_d  = 1'b0;
        post_d  = '0;
      end else begin
        unique case (state_q)
          ARMED: begin
            if (match) begin
              trig_d = 1'b1;
              if (cfg_post_count == '0) begin
                state_d = DONE;
              end else begin
                post_d  = cfg_post_count;
                state_d = POST;
              end
            end
          end
          POST: begin
            if (mcu_trace_rv_i_valid_ip) begin
              post_d = post_q - POST_CNT_WIDTH'(1);
              if (post_q == POST_CNT_WIDTH'(1)) begin
                state_d = DONE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Saturating count of packets handed to the buffer
  always_comb begin
    fwd_cnt_d = fwd_cnt_q;
    if (fwd && (fwd_cnt_q != 32'hFFFF_FFFF)) begin
      fwd_cnt_d = fwd_cnt_q + 32'd1;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      trig_q    <= 1'b0;
      post_q    <= '0;
      fwd_cnt_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      trig_q    <= trig_d;
      post_q    <= post_d;
      fwd_cnt_q <= fwd_cnt_d;
      valid_q   <= fwd;
    end
  end

  // Packet fields load only on forward and hold otherwise
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      insn_q   <= '0;
      addr_q   <= '0;
      tval_q   <= '0;
      exc_q    <= 1'b0;
      intr_q   <= 1'b0;
      ecause_q <= '0;
    end else if (fwd) begin
      insn_q   <= mcu_trace_rv_i_insn_ip;
      addr_q   <= mcu_trace_rv_i_address_ip;
      tval_q   <= mcu_trace_rv_i_tval_ip;
      exc_q    <= mcu_trace_rv_i_exception_ip;
      intr_q   <= mcu_trace_rv_i_interrupt_ip;
      ecause_q <= mcu_trace_rv_i_ecause_ip;
    end
  end

  assign trace_o_valid     = valid_q;
  assign trace_o_insn      = insn_q;
  assign trace_o_address   = addr_q;
  assign trace_o_tval      = tval_q;
  assign trace_o_exception = exc_q;
  assign trace_o_interrupt = intr_q;
  assign trace_o_ecause    = ecause_q;
  assign state             = state_q;
  assign triggered         = trig_q;
  assign post_remaining    = post_q;
  assign fwd_count         = fwd_cnt_q;

endmodule

// File: tb/tb_mci_mcu_trace_trigger.sv
// Bench for mci_mcu_trace_trigger: vector tables with a packet scoreboard
// plus hand-written sequences for trigger, debug-drop and reset corners.
module tb_mci_mcu_trace_trigger;

  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          debug_en;
  logic          cfg_trig_en;
  logic          cfg_arm;
  logic          cfg_disarm;
  logic [31:0]   cfg_trig_addr;
  logic [31:0]   cfg_trig_mask;
  logic          cfg_trig_on_exc;
  logic [PW-1:0] cfg_post_count;
  logic [31:0]   in_insn, in_addr, in_tval;
  logic          in_valid, in_exc, in_intr;
  logic [4:0]    in_ec;
  logic [31:0]   trace_o_insn, trace_o_address, trace_o_tval;
  logic          trace_o_valid, trace_o_exception, trace_o_interrupt;
  logic [4:0]    trace_o_ecause;
  logic [1:0]    state;
  logic          triggered;
  logic [PW-1:0] post_remaining;
  logic [31:0]   fwd_count;

  mci_mcu_trace_trigger #(.POST_CNT_WIDTH(PW)) dut (
    .clk                         (clk),
    .rst_b                       (rst_b),
    .debug_en                    (debug_en),
    .cfg_trig_en                 (cfg_trig_en),
    .cfg_arm                     (cfg_arm),
    .cfg_disarm                  (cfg_disarm),
    .cfg_trig_addr               (cfg_trig_addr),
    .cfg_trig_mask               (cfg_trig_mask),
    .cfg_trig_on_exc             (cfg_trig_on_exc),
    .cfg_post_count              (cfg_post_count),
    .mcu_trace_rv_i_insn_ip      (in_insn),
    .mcu_trace_rv_i_address_ip   (in_addr),
    .mcu_trace_rv_i_tval_ip      (in_tval),
    .mcu_trace_rv_i_valid_ip     (in_valid),
    .mcu_trace_rv_i_exception_ip (in_exc),
    .mcu_trace_rv_i_interrupt_ip (in_intr),
    .mcu_trace_rv_i_ecause_ip    (in_ec),
    .trace_o_insn                (trace_o_insn),
    .trace_o_address             (trace_o_address),
    .trace_o_tval                (trace_o_tval),
    .trace_o_valid               (trace_o_valid),
    .trace_o_exception           (trace_o_exception),
    .trace_o_interrupt           (trace_o_interrupt),
    .trace_o_ecause              (trace_o_ecause),
    .state                       (state),
    .triggered                   (triggered),
    .post_remaining              (post_remaining),
    .fwd_count                   (fwd_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       dbg;
    logic       ten;
    logic       arm;
    logic       dis;
    logic       vld;
    logic       exc;
    logic [31:0] pc;
    logic [4:0] ec;
    logic       fwd;
    logic [1:0] st;
  } vec_t;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] addr;
    logic [31:0] tval;
    logic        exc;
    logic        intr;
    logic [4:0]  ec;
  } pkt_t;

  vec_t tbl[$];
  pkt_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(
    logic dbg, logic ten, logic arm, logic dis, logic vld,
    logic exc, logic [31:0] pc, logic [4:0] ec,
    logic fwd, logic [1:0] st);
    vec_t v;
    v.dbg = dbg; v.ten = ten; v.arm = arm; v.dis = dis;
    v.vld = vld; v.exc = exc; v.pc = pc; v.ec = ec;
    v.fwd = fwd; v.st = st;
    return v;
  endfunction

  function automatic pkt_t mkpkt(vec_t v);
    pkt_t p;
    p.insn = v.pc ^ 32'hA5A5_0013;
    p.addr = v.pc;
    p.tval = ~v.pc;
    p.exc  = v.exc;
    p.intr = v.pc[2];
    p.ec   = v.ec;
    return p;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(vec_t t);
    pkt_t p;
    pkt_t e;
    @(negedge clk);
    p = mkpkt(t);
    debug_en    = t.dbg;
    cfg_trig_en = t.ten;
    cfg_arm     = t.arm;
    cfg_disarm  = t.dis;
    in_valid    = t.vld;
    in_insn     = p.insn;
    in_addr     = p.addr;
    in_tval     = p.tval;
    in_exc      = p.exc;
    in_intr     = p.intr;
    in_ec       = p.ec;
    if (t.fwd) sb.push_back(p);
    @(posedge clk);
    #1;
    chk("valid", trace_o_valid, t.fwd);
    if (trace_o_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_pkt", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("pkt", {trace_o_insn, trace_o_address, trace_o_tval,
          trace_o_exception, trace_o_interrupt, trace_o_ecause}, e);
      end
    end
    chk("state", state, t.st);
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) step(tbl[i]);
    tbl.delete();
  endtask

  initial begin
    rst_b = 1'b0;
    debug_en = 0; cfg_trig_en = 0; cfg_arm = 0; cfg_disarm = 0;
    cfg_trig_addr = 32'h1000; cfg_trig_mask = 32'hFFFF_FFFF;
    cfg_trig_on_exc = 0; cfg_post_count = 16'd3;
    in_insn = 0; in_addr = 0; in_tval = 0;
    in_valid = 0; in_exc = 0; in_intr = 0; in_ec = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_trig", triggered, 0);
    chk("rst_post", post_remaining, 0);
    chk("rst_fwd", fwd_count, 0);
    chk("rst_valid", trace_o_valid, 0);
    chk("rst_insn", trace_o_insn, 0);
    @(negedge clk);
    rst_b = 1'b1;

    // free-run: ten back-to-back packets
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(1, 0, 0, 0, 1, i[0], 32'h400 + 32'(i * 4),
        5'(i), 1, 0));
    run_tbl();
    chk("fr_count", fwd_count, 10);

    // address trigger with three post-trigger packets
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 32'h0,    0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 32'h0,    0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 32'hF00,  0, 1, 1));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 32'h1000, 0, 1, 2));
    run_tbl();
    chk("at_post3", post_remaining, 3);
    chk("at_trig", triggered, 1);
    cfg_post_count = 16'd9;
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 32'h1004, 0, 1, 2));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 32'h0,    0, 0, 2));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 32'h1008, 0, 1, 2));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 32'h100C, 0, 1, 3));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 32'h1010, 0, 0, 3));
    run_tbl();
    chk("at_trig_done", triggered, 1);
    chk("at_post0", post_remaining, 0);
    chk("at_count", fwd_count, 15);

    // exception trigger straight to DONE
    cfg_post_count = 16'd0;
    cfg_trig_on_exc = 1'b1;
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 32'h0,    0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 32'h2000, 0, 1, 1));
    tbl.push_back(mk(1, 1, 0, 0, 1, 1, 32'h2004, 2, 1, 3));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 32'h2008, 0, 0, 3));
    run_tbl();
    chk("ex_ecause_hold", trace_o_ecause, 2);
    chk("ex_addr_hold", trace_o_address, 32'h2004);
    chk("ex_trig", triggered, 1);
    chk("ex_count", fwd_count, 17);

    // arm and disarm together while a packet arrives
    cfg_trig_on_exc = 1'b0;
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 32'h0,    0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 1, 1, 0, 32'h3000, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 32'h3004, 0, 0, 0));
    run_tbl();
    chk("col_count", fwd_count, 18);

    // debug drop in POST
    cfg_post_count = 16'd5;
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 32'h0,    0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 32'h1000, 0, 1, 2));
    run_tbl();
    chk("dbg_post5", post_remaining, 5);
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 32'h1004, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 32'h1008, 0, 0, 0));
    run_tbl();
    chk("dbg_post0", post_remaining, 0);
    chk("dbg_trig", triggered, 0);
    chk("dbg_count", fwd_count, 19);
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 32'h0, 0, 0, 1));
    run_tbl();

    // saturation of the forwarded-packet counter
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 32'h0, 0, 0, 0));
    run_tbl();
    force dut.fwd_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.fwd_cnt_q;
    chk("sat_preset", fwd_count, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, 0, 0, 0, 1, 0, 32'h5000 + 32'(i * 4),
        0, 1, 0));
    run_tbl();
    chk("sat_count", fwd_count, 32'hFFFF_FFFF);

    // reset in the middle of POST
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 32'h0,    0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 32'h1000, 0, 1, 2));
    run_tbl();
    @(negedge clk);
    in_valid = 1'b1;
    rst_b = 1'b0;
    #1;
    chk("mr_state", state, 0);
    chk("mr_post", post_remaining, 0);
    chk("mr_trig", triggered, 0);
    chk("mr_count", fwd_count, 0);
    chk("mr_addr", trace_o_address, 0);
    @(posedge clk);
    #1;
    chk("mr_valid", trace_o_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_b = 1'b1;

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
